// File: rtl/frame_pkg.sv
// Shared types for the packed-frame byte link (serializer and deserializer).
package frame_pkg;

  localparam int unsigned LEN_W = 6;

  typedef enum logic [1:0] {TAG_DATA, TAG_CTRL, TAG_STAT, TAG_RSVD} tag_e;

  typedef struct packed {
    tag_e             tag;
    logic [LEN_W-1:0] len;
  } hdr_t;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} ser_state_e;

  // Requested length clamped to the payload capacity of the word.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len,
                                               input int unsigned       max_len);
    if (32'(len) > max_len) return LEN_W'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/frame_serializer.sv
// Word-to-byte frame serializer: emits a header byte, then payload bytes LSB first.
module frame_serializer
  import frame_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_tag,
  input  logic [5:0]              in_len,
  input  logic [DATA_BYTES*8-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic                    out_first,
  output logic                    out_last
);

  localparam int unsigned CNT_W = $clog2(DATA_BYTES + 1);

  ser_state_e                  state_q, state_d;
  tag_e                        tag_q, tag_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic [DATA_BYTES-1:0][7:0]  data_q, data_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic       accept;
  logic       done;
  logic       byte_last;
  logic [7:0] pay_byte;
  hdr_t       hdr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tag_q   <= TAG_DATA;
      len_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      len_q   <= len_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pay_byte = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (32'(cnt_q) == i) pay_byte = data_q[i];
    end
  end

  assign byte_last = (LEN_W'(cnt_q) == (len_q - 6'd1));
  assign hdr       = '{tag: tag_q, len: len_q};

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    len_d   = len_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_HDR: begin
        if (out_ready) state_d = (len_q != '0) ? S_PAY : S_IDLE;
      end
      S_PAY: begin
        if (out_ready) begin
          if (byte_last) state_d = S_IDLE;
          else           cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    // A frame accepted on the completing handshake skips IDLE entirely.
    if (accept) begin
      state_d = S_HDR;
      tag_d   = tag_e'(in_tag);
      len_d   = eff_len(in_len, DATA_BYTES);
      data_d  = in_data;
      cnt_d   = '0;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state_q)
      S_HDR: begin
        out_valid = 1'b1;
        out_first = 1'b1;
        out_last  = (len_q == '0);
        out_data  = hdr;
      end
      S_PAY: begin
        out_valid = 1'b1;
        out_last  = byte_last;
        out_data  = pay_byte;
      end
      default: ;
    endcase
    done     = out_valid && out_ready && out_last;
    in_ready = (state_q == S_IDLE) || done;
    accept   = in_valid && in_ready;
  end

endmodule
